// File: rtl/pio_clkdiv_ctrl.sv
// pio_clkdiv_ctrl: per-state-machine 16.8 fractional clock divider for the PIO block.
// Each SM holds a CLKDIV register {INT, FRAC} and emits a one-cycle penable pulse
// whose spacing averages INT + FRAC/2^FRAC_W enabled cycles.
// Optional build macro PIO_CLKDIV_PCLK_EN adds a per-SM toggle flop output (pclk)
// giving a divided, roughly 50%-duty debug clock.
module pio_clkdiv_ctrl #(
  parameter int unsigned NUM_SM = 4,
  parameter int unsigned INT_W  = 16,
  parameter int unsigned FRAC_W = 8,
  localparam int unsigned SW    = (NUM_SM > 1) ? $clog2(NUM_SM) : 1,
  localparam int unsigned DW    = INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [SW-1:0]     cfg_sm,
  input  logic [DW-1:0]     cfg_div,
  input  logic [SW-1:0]     rd_sm,
  output logic [DW-1:0]     rd_div,
  input  logic [NUM_SM-1:0] sm_en,
  input  logic [NUM_SM-1:0] restart,
  output logic [NUM_SM-1:0] penable
`ifdef PIO_CLKDIV_PCLK_EN
  ,
  output logic [NUM_SM-1:0] pclk
`endif
);

  localparam int unsigned CW = INT_W + 1;

  // INT of zero means a divide by 2^INT_W
  function automatic logic [CW-1:0] int_eff(input logic [INT_W-1:0] i);
    return (i == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, i};
  endfunction

  logic [DW-1:0] div_arr [NUM_SM];

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    localparam int unsigned IDX = g;

    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic              wr_hit;
    logic              hit;

    assign wr_hit     = cfg_wr && (32'(cfg_sm) == IDX);
    assign hit        = (cnt_q == len_q);
    assign acc_sum    = {1'b0, acc_q} + {1'b0, div_q[FRAC_W-1:0]};
    assign penable[g] = ~reset & sm_en[g] & hit & ~restart[g];
    assign div_arr[g] = div_q;

    // Next-state: restart reloads from the post-write value, pulse cycles use the current one
    always_comb begin
      div_d = wr_hit ? cfg_div : div_q;
      cnt_d = cnt_q;
      len_d = len_q;
      acc_d = acc_q;
      if (restart[g]) begin
        cnt_d = CW'(1);
        acc_d = '0;
        len_d = int_eff(div_d[DW-1:FRAC_W]);
      end else if (sm_en[g]) begin
        if (hit) begin
          cnt_d = CW'(1);
          acc_d = acc_sum[FRAC_W-1:0];
          len_d = int_eff(div_q[DW-1:FRAC_W]) + CW'(acc_sum[FRAC_W]);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
      if (reset) begin
        div_q <= {INT_W'(1), FRAC_W'(0)};
        cnt_q <= CW'(1);
        len_q <= CW'(1);
        acc_q <= '0;
      end else begin
        div_q <= div_d;
        cnt_q <= cnt_d;
        len_q <= len_d;
        acc_q <= acc_d;
      end
    end

`ifdef PIO_CLKDIV_PCLK_EN
    // Debug clock toggles once per penable pulse, cleared by restart
    always_ff @(posedge clk) begin
      if (reset || restart[g]) begin
        pclk[g] <= 1'b0;
      end else if (penable[g]) begin
        pclk[g] <= ~pclk[g];
      end
    end
`endif
  end

  // Readback, zero for indices with no SM behind them
  always_comb begin
    rd_div = '0;
    if (32'(rd_sm) < NUM_SM) begin
      rd_div = div_arr[rd_sm];
    end
  end

endmodule

// File: tb/tb_pio_clkdiv_ctrl.sv
// tb_pio_clkdiv_ctrl: directed self-checking bench for pio_clkdiv_ctrl.
// A second 3-SM instance exercises out-of-range write/readback indices.
module tb_pio_clkdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr;
  logic [1:0]  cfg_sm;
  logic [23:0] cfg_div;
  logic [1:0]  rd_sm;
  logic [23:0] rd_div;
  logic [3:0]  sm_en;
  logic [3:0]  restart;
  logic [3:0]  penable;

  logic        cfg_wr3;
  logic [1:0]  cfg_sm3;
  logic [23:0] cfg_div3;
  logic [1:0]  rd_sm3;
  logic [23:0] rd_div3;
  logic [2:0]  penable3;

`ifdef PIO_CLKDIV_PCLK_EN
  logic [3:0]  pclk;
  logic [2:0]  pclk3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_clkdiv_ctrl dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_sm(cfg_sm), .cfg_div(cfg_div),
    .rd_sm(rd_sm), .rd_div(rd_div), .sm_en(sm_en), .restart(restart), .penable(penable)
`ifdef PIO_CLKDIV_PCLK_EN
    , .pclk(pclk)
`endif
  );

  pio_clkdiv_ctrl #(.NUM_SM(3)) dut3 (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr3), .cfg_sm(cfg_sm3), .cfg_div(cfg_div3),
    .rd_sm(rd_sm3), .rd_div(rd_div3), .sm_en(3'b111), .restart(3'b000), .penable(penable3)
`ifdef PIO_CLKDIV_PCLK_EN
    , .pclk(pclk3)
`endif
  );

  // Advance to 1 time unit after the next rising edge (input drive point)
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, drop one-shot strobes, record penable[idx] per cycle (bit k = cycle k+1)
  task automatic run_obs(input int idx, input int n, output logic [63:0] obs);
    obs = '0;
    for (int k = 0; k < n; k++) begin
      edge_step();
      cfg_wr  = 1'b0;
      restart = '0;
      #1;
      obs[k] = penable[idx];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_wr = 1'b0; cfg_sm = '0; cfg_div = '0; rd_sm = '0;
    sm_en = 4'b1111; restart = '0;
    cfg_wr3 = 1'b0; cfg_sm3 = '0; cfg_div3 = '0; rd_sm3 = '0;
    repeat (3) edge_step();
    #1;
    n_tests++;
    if (penable !== 4'b0000) begin
      n_fail++; $display("FAIL reset_penable: got %b want 0000", penable);
    end
    for (int s = 0; s < 4; s++) begin
      rd_sm = 2'(s);
      #1;
      n_tests++;
      if (rd_div !== 24'h000100) begin
        n_fail++; $display("FAIL reset_rd_div[%0d]: got %h want 000100", s, rd_div);
      end
    end
`ifdef PIO_CLKDIV_PCLK_EN
    n_tests++;
    if (pclk !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pclk: got %b want 0000", pclk);
    end
`endif
  endtask

  task automatic test_div1();
    edge_step();
    reset = 1'b0; sm_en = 4'b0001; rd_sm = 2'd0;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (penable !== 4'b0001) begin
        n_fail++; $display("FAIL div1_cycle%0d: got %b want 0001", k, penable);
      end
      edge_step();
      #1;
    end
    n_tests++;
    if (rd_div !== 24'h000100) begin
      n_fail++; $display("FAIL div1_rd_div: got %h want 000100", rd_div);
    end
  endtask

  task automatic test_div3();
    logic [63:0] obs;
    cfg_wr = 1'b1; cfg_sm = 2'd1; cfg_div = 24'h000300; restart = 4'b0010; sm_en = 4'b0011;
    #1;
    n_tests++;
    if (penable !== 4'b0001) begin
      n_fail++; $display("FAIL div3_restart_cycle: got %b want 0001", penable);
    end
    run_obs(1, 9, obs);
    n_tests++;
    if (obs[8:0] !== 9'b100100100) begin
      n_fail++; $display("FAIL div3_pattern: got %b want 100100100", obs[8:0]);
    end
    rd_sm = 2'd1;
    #1;
    n_tests++;
    if (rd_div !== 24'h000300) begin
      n_fail++; $display("FAIL div3_rd_div: got %h want 000300", rd_div);
    end
  endtask

  task automatic test_frac();
    logic [63:0] obs;
    logic [24:0] exp_pat;
    int          times [10] = '{2, 4, 7, 9, 12, 14, 17, 19, 22, 24};
    exp_pat = '0;
    foreach (times[i]) exp_pat[times[i] - 1] = 1'b1;
    edge_step();
    cfg_wr = 1'b1; cfg_sm = 2'd2; cfg_div = 24'h000280; restart = 4'b0100; sm_en = 4'b0111;
    #1;
    n_tests++;
    if (penable[2] !== 1'b0) begin
      n_fail++; $display("FAIL frac_restart_suppress: got %b want 0", penable[2]);
    end
    run_obs(2, 25, obs);
    n_tests++;
    if (obs[24:0] !== exp_pat) begin
      n_fail++; $display("FAIL frac_pattern: got %b want %b", obs[24:0], exp_pat);
    end
    n_tests++;
    if ($countones(obs[24:0]) != 10) begin
      n_fail++; $display("FAIL frac_count: got %0d want 10", $countones(obs[24:0]));
    end
    rd_sm = 2'd2;
    #1;
    n_tests++;
    if (rd_div !== 24'h000280) begin
      n_fail++; $display("FAIL frac_rd_div: got %h want 000280", rd_div);
    end
  endtask

  task automatic test_enable_gate();
    logic [63:0] obs;
    edge_step();
    restart = 4'b0010;
    obs = '0;
    for (int k = 1; k <= 11; k++) begin
      edge_step();
      restart  = '0;
      sm_en[1] = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
      #1;
      obs[k - 1] = penable[1];
    end
    n_tests++;
    if (obs[10:0] !== 11'b10010000000) begin
      n_fail++; $display("FAIL enable_gate_pattern: got %b want 10010000000", obs[10:0]);
    end
  endtask

  task automatic test_live_write();
    logic [63:0] obs;
    int          first;
    edge_step();
    cfg_wr = 1'b1; cfg_sm = 2'd0; cfg_div = 24'h000400; restart = 4'b0001;
    obs = '0;
    for (int k = 1; k <= 10; k++) begin
      edge_step();
      cfg_wr  = (k == 2);
      cfg_div = 24'h000200;
      restart = '0;
      #1;
      obs[k - 1] = penable[0];
    end
    n_tests++;
    if (obs[9:0] !== 10'b1010101000) begin
      n_fail++; $display("FAIL live_write_pattern: got %b want 1010101000", obs[9:0]);
    end
    rd_sm = 2'd0;
    #1;
    n_tests++;
    if (rd_div !== 24'h000200) begin
      n_fail++; $display("FAIL live_write_rd_div: got %h want 000200", rd_div);
    end
    edge_step();
    cfg_wr = 1'b1; cfg_sm = 2'd0; cfg_div = 24'h000000; restart = 4'b0001;
    first = 0;
    for (int k = 1; k <= 65600 && first == 0; k++) begin
      edge_step();
      cfg_wr  = 1'b0;
      restart = '0;
      #1;
      if (penable[0] === 1'b1) first = k;
    end
    n_tests++;
    if (first != 65536) begin
      n_fail++; $display("FAIL div65536_first_pulse: got cycle %0d want 65536", first);
    end
    n_tests++;
    if (rd_div !== 24'h000000) begin
      n_fail++; $display("FAIL div65536_rd_div: got %h want 000000", rd_div);
    end
  endtask

  task automatic test_out_of_range();
    edge_step();
    cfg_wr3 = 1'b1; cfg_sm3 = 2'd3; cfg_div3 = 24'h000500;
    edge_step();
    cfg_wr3 = 1'b1; cfg_sm3 = 2'd2; cfg_div3 = 24'h000700;
    edge_step();
    cfg_wr3 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rd_sm3 = 2'(s);
      #1;
      n_tests++;
      if (rd_div3 !== ((s == 2) ? 24'h000700 : (s == 3) ? 24'h000000 : 24'h000100)) begin
        n_fail++; $display("FAIL oor_rd_div[%0d]: got %h", s, rd_div3);
      end
    end
  endtask

  task automatic test_reset_mid();
    edge_step();
    sm_en = 4'b1111;
    edge_step();
    reset = 1'b1;
    #1;
    n_tests++;
    if (penable !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_penable: got %b want 0000", penable);
    end
    edge_step();
    reset = 1'b0;
    #1;
`ifdef PIO_CLKDIV_PCLK_EN
    n_tests++;
    if (pclk !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_pclk0: got %b want 0000", pclk);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (penable !== 4'b1111) begin
        n_fail++; $display("FAIL reset_mid_div1_cycle%0d: got %b want 1111", k, penable);
      end
      edge_step();
      #1;
`ifdef PIO_CLKDIV_PCLK_EN
      n_tests++;
      if (pclk !== ((k % 2 == 0) ? 4'b1111 : 4'b0000)) begin
        n_fail++; $display("FAIL reset_mid_pclk_toggle%0d: got %b", k, pclk);
      end
`endif
    end
    for (int s = 0; s < 4; s++) begin
      rd_sm = 2'(s);
      #1;
      n_tests++;
      if (rd_div !== 24'h000100) begin
        n_fail++; $display("FAIL reset_mid_rd_div[%0d]: got %h want 000100", s, rd_div);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_frac();
    test_enable_gate();
    test_out_of_range();
    test_live_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
